fifo_mc_clearable: RTL and testbench
====================================

# fifo_mc_clearable

Single-clock, multi-channel FIFO with a per-channel clear sequence. It provides NUM_CH independent queues of 2**LOG_DEPTH entries each, with separate valid/ready handshakes on both sides. Each channel can be cleared individually by an isolate-then-flush sequence that never produces spurious or duplicated transfers. It sits on the synchronous side of clearable CDC links and in multi-stream DMA/interconnect buffering.

## Interface
- NUM_CH, default 4: number of independent channels, ≥1.
- WIDTH, default 8: payload width for the default T.
- T, default logic [WIDTH-1:0]: payload type.
- LOG_DEPTH, default 2: per-channel depth is 2**LOG_DEPTH; must be ≥1.
- clk_i  input  1  clock; all logic samples on its rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- clear_i  input  NUM_CH  per-channel synchronous clear request.
- clear_pending_o  output  NUM_CH  channel is in its clear sequence.
- in_data_i  input  NUM_CH×T  write payload per channel.
- in_valid_i  input  NUM_CH  write valid per channel.
- in_ready_o  output  NUM_CH  write ready per channel.
- out_data_o  output  NUM_CH×T  head-of-queue payload per channel.
- out_valid_o  output  NUM_CH  read valid per channel.
- out_ready_i  input  NUM_CH  read ready per channel.
- usage_o  output  NUM_CH×(LOG_DEPTH+1)  fill level per channel. Present only with FIFO_MC_USAGE_EN.

## Operation
- Each channel has binary write and read pointers of LOG_DEPTH+1 bits.
  - Count = wptr − rptr, computed modulo 2**(LOG_DEPTH+1).
  - Empty when count == 0; full when count == 2**LOG_DEPTH.
  - Pointers wrap naturally; the storage index is ptr[LOG_DEPTH-1:0].
- A push occurs when in_valid_i & in_ready_o.
  - The payload is stored at wptr, and wptr increments.
  - Storage registers are not reset.
- A pop occurs when out_valid_o & out_ready_i, and rptr increments.
  - out_data_o = storage[rptr] with no fall-through; it is undefined when out_valid_o = 0.
- Handshake signals:
  - in_ready_o = (state == IDLE) & !full.
  - out_valid_o = (state == IDLE) & !empty.
  - Neither signal depends on the other side's valid or ready.
- When a channel is full, a simultaneous pop does not enable a push in the same cycle.
- Per-channel clear FSM:
  - IDLE: on clear_i = 1, go to ISOLATE. Handshakes in that same cycle still complete normally.
  - ISOLATE: one cycle with clear_pending_o = 1 and both handshakes blocked, then go to FLUSH.
  - FLUSH: clear_pending_o = 1. wptr and rptr load 0 at the end of this cycle. Next state is ISOLATE if clear_i = 1, else IDLE.
- clear_i is ignored while the channel is in ISOLATE.
- Channels are fully independent: a clear on channel k never affects any other channel's pointers, handshakes or data.
- Values at reset (and immediately after it): all pointers 0; all FSMs IDLE.
  - in_ready_o all 1; out_valid_o all 0; clear_pending_o all 0; usage_o all 0.

## Timing
- Write-to-read latency is 1 cycle: data pushed in cycle n gives out_valid_o = 1 in cycle n+1.
- Throughput: 1 push and 1 pop per channel per cycle, sustained when the channel is neither empty nor full.
- Clear latency, with clear_i high only in cycle n:
  - clear_pending_o = 1 in cycles n+1 and n+2.
  - The channel is empty and back in IDLE in cycle n+3.
  - in_ready_o = 1 in cycle n+3.
- With clear_i held high, ISOLATE and FLUSH alternate, and clear_pending_o stays 1 until 1 cycle after clear_i is sampled low in FLUSH.
- An asynchronous reset mid-sequence aborts the clear and gives the reset values immediately.
- Combinational paths:
  - in_ready_o, out_valid_o and out_data_o are driven from registers only.
  - There is no combinational path from inputs to outputs.

## Configuration
- FIFO_MC_USAGE_EN defined:
  - usage_o is present and equals the registered count per channel.
  - usage_o reads 0 during FLUSH's following cycle onward.
- FIFO_MC_USAGE_EN undefined:
  - The usage_o port and its logic are omitted.
  - All other behaviour is identical.

## Test plan
- Reset, LOG_DEPTH=2, NUM_CH=4 -> in_ready_o=4'b1111, out_valid_o=4'b0000, clear_pending_o=0.
- Push 0x11, 0x22, 0x33, 0x44 into ch0 with out_ready_i=0:
  - Required: in_ready_o[0]=0 after the 4th push; usage_o[0]=4.
  - Then pop all 4: order is 0x11..0x44, and out_valid_o[0]=0 afterwards.
- Streaming on ch1, push and pop every cycle for 20 words 0x00..0x13:
  - Required: all words received in order; no stall after the first cycle; pointers wrap twice.
- ch2 holds 3 entries; clear_i[2] pulses for 1 cycle while ch3 streams:
  - Required: clear_pending_o[2]=1 for exactly 2 cycles; out_valid_o[2]=0 afterwards.
  - Required: ch3 is uninterrupted and its data is intact.
- clear_i[0] is held high for 5 cycles:
  - Required: clear_pending_o[0] stays high until 1 cycle after release.
  - Required: no push is accepted while clear_pending_o[0]=1.
- rst_ni asserted during the ISOLATE state of ch1:
  - Required: reset values appear immediately, and ch1 is IDLE and empty after release.

Source files
------------

// File: rtl/fifo_mc_clearable.sv
// fifo_mc_clearable: NUM_CH independent FIFOs of 2**LOG_DEPTH entries, each with its own isolate-then-flush clear.
// Latency: a word pushed in cycle n is visible at the read side in cycle n+1; a clear returns to IDLE 3 cycles after the request.
// Backpressure: in_ready_o drops when full or clearing, and out_valid_o drops when empty or clearing; neither side looks at the other.
//
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   clear_i / clear_pending_o   per-channel clear request / channel is in its clear sequence
//   in_data_i/in_valid_i/in_ready_o     write side, channel c at in_data_i[c*$bits(T) +: $bits(T)]
//   out_data_o/out_valid_o/out_ready_i  read side, same packing as the write side
//   usage_o                     per-channel fill level, LOG_DEPTH+1 bits each; present only when
//                               FIFO_MC_USAGE_EN is defined
module fifo_mc_clearable #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned WIDTH     = 8,
  parameter type         T         = logic [WIDTH-1:0],
  parameter int unsigned LOG_DEPTH = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_CH-1:0]           clear_i,
  output logic [NUM_CH-1:0]           clear_pending_o,
  input  logic [NUM_CH*$bits(T)-1:0]  in_data_i,
  input  logic [NUM_CH-1:0]           in_valid_i,
  output logic [NUM_CH-1:0]           in_ready_o,
  output logic [NUM_CH*$bits(T)-1:0]  out_data_o,
  output logic [NUM_CH-1:0]           out_valid_o,
  input  logic [NUM_CH-1:0]           out_ready_i
`ifdef FIFO_MC_USAGE_EN
  ,
  output logic [NUM_CH*(LOG_DEPTH+1)-1:0] usage_o
`endif
);

  localparam int unsigned DW = $bits(T);
  localparam int unsigned PW = LOG_DEPTH + 1;
  localparam logic [PW-1:0] DEPTH_CNT = PW'(1) << LOG_DEPTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISOLATE = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e          state_q, state_d;
    logic [PW-1:0]   wptr_q, rptr_q, count;
    logic [DW-1:0]   mem_q [2**LOG_DEPTH];
    logic            full, empty, push, pop;
    logic            rdy, vld, pending;

    // One extra pointer bit distinguishes full from empty; the subtraction wraps naturally.
    assign count = wptr_q - rptr_q;
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
    end

    // Next state: clear_i is not looked at in ISOLATE, so a held request alternates ISOLATE/FLUSH.
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        IDLE:    if (clear_i[c]) state_d = ISOLATE;
        ISOLATE: state_d = FLUSH;
        FLUSH:   state_d = clear_i[c] ? ISOLATE : IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Outputs: handshakes are open only in IDLE, so the request cycle itself still transfers.
    always_comb begin
      rdy     = 1'b0;
      vld     = 1'b0;
      pending = 1'b0;
      if (state_q == IDLE) begin
        rdy = !full;
        vld = !empty;
      end else begin
        pending = 1'b1;
      end
    end

    assign push = in_valid_i[c] & rdy;
    assign pop  = out_ready_i[c] & vld;

    // Pointers; both handshakes are blocked in FLUSH, so zeroing here cannot lose a transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else if (state_q == FLUSH) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + PW'(1);
        if (pop)  rptr_q <= rptr_q + PW'(1);
      end
    end

    // Payload storage carries no reset; contents are only observed behind out_valid_o.
    always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q[LOG_DEPTH-1:0]] <= in_data_i[c*DW +: DW];
    end

    assign in_ready_o[c]            = rdy;
    assign out_valid_o[c]           = vld;
    assign clear_pending_o[c]       = pending;
    assign out_data_o[c*DW +: DW]   = mem_q[rptr_q[LOG_DEPTH-1:0]];
`ifdef FIFO_MC_USAGE_EN
    assign usage_o[c*PW +: PW]      = count;
`endif
  end

endmodule

// File: tb/tb_fifo_mc_clearable.sv
module tb_fifo_mc_clearable;
  localparam int NUM_CH = 4;
  localparam int W      = 8;
  localparam int LD     = 2;
  localparam int DEPTH  = 4;

  logic                  clk;
  logic                  rst_ni;
  logic [NUM_CH-1:0]     clear;
  logic [NUM_CH-1:0]     pending;
  logic [NUM_CH*W-1:0]   in_data;
  logic [NUM_CH-1:0]     in_valid;
  logic [NUM_CH-1:0]     in_ready;
  logic [NUM_CH*W-1:0]   out_data;
  logic [NUM_CH-1:0]     out_valid;
  logic [NUM_CH-1:0]     out_ready;
`ifdef FIFO_MC_USAGE_EN
  logic [NUM_CH*(LD+1)-1:0] usage;
`endif

  int total = 0;
  int bad   = 0;

  fifo_mc_clearable #(.NUM_CH(NUM_CH), .WIDTH(W), .LOG_DEPTH(LD)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .clear_i         (clear),
    .clear_pending_o (pending),
    .in_data_i       (in_data),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .out_data_o      (out_data),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready)
`ifdef FIFO_MC_USAGE_EN
    ,
    .usage_o         (usage)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue of words per channel, plus the clear phase
  // (0 = normal, 1 = isolating, 2 = flushing) as the clear rules describe it.
  logic [W-1:0] mq [NUM_CH][$];
  int           ph [NUM_CH];

  function automatic logic [NUM_CH-1:0] e_rdy();
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = (ph[c] == 0) && (mq[c].size() < DEPTH);
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] e_vld();
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = (ph[c] == 0) && (mq[c].size() > 0);
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] e_pend();
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = (ph[c] != 0);
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      mq[c].delete();
      ph[c] = 0;
    end
  endtask

  // Advance one clock (negedge to negedge) and update the model with the inputs that were applied.
  task automatic tick();
    logic [NUM_CH-1:0] pu, po;
    pu = in_valid & e_rdy();
    po = out_ready & e_vld();
    @(posedge clk);
    for (int c = 0; c < NUM_CH; c++) begin
      if (ph[c] == 2) mq[c].delete();
      else begin
        if (po[c]) void'(mq[c].pop_front());
        if (pu[c]) mq[c].push_back(in_data[c*W +: W]);
      end
      case (ph[c])
        0:       ph[c] = clear[c] ? 1 : 0;
        1:       ph[c] = 2;
        default: ph[c] = clear[c] ? 1 : 0;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_ni = 1'b1; clear = '0; in_valid = '0; out_ready = '0; in_data = '0;
    #2 rst_ni = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 4'b1111) begin bad++; $display("FAIL reset_in_ready got=%b exp=1111", in_ready); end
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid); end
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL reset_pending got=%b exp=0000", pending); end
`ifdef FIFO_MC_USAGE_EN
    total++; if (usage !== '0) begin bad++; $display("FAIL reset_usage got=%h exp=0", usage); end
`endif
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      in_valid[0] = 1'b1;
      in_data[7:0] = 8'(8'h11 * (i + 1));
      tick();
    end
    in_valid[0] = 1'b0;
    total++; if (in_ready[0] !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%b exp=0", in_ready[0]); end
`ifdef FIFO_MC_USAGE_EN
    total++; if (usage[2:0] !== 3'd4) begin bad++; $display("FAIL fill_usage got=%0d exp=4", usage[2:0]); end
`endif
    // A pop on a full channel must not let a push in during the same cycle.
    in_valid[0] = 1'b1; in_data[7:0] = 8'hEE; out_ready[0] = 1'b1;
    total++; if (out_data[7:0] !== 8'h11 || out_valid[0] !== 1'b1) begin
      bad++; $display("FAIL drain_0 got=%h/%b exp=11/1", out_data[7:0], out_valid[0]); end
    tick();
    in_valid[0] = 1'b0;
    for (int i = 1; i < 4; i++) begin
      total++; if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'(8'h11 * (i + 1))) begin
        bad++; $display("FAIL drain_%0d got=%h/%b exp=%h/1", i, out_data[7:0], out_valid[0], 8'(8'h11 * (i + 1))); end
      tick();
    end
    out_ready[0] = 1'b0;
    total++; if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", out_valid[0]); end
  endtask

  task automatic test_stream();
    int rx;
    rx = 0;
    out_ready[1] = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      in_valid[1] = (i < 20);
      in_data[15:8] = 8'(i);
      if (i < 20) begin
        total++; if (in_ready[1] !== 1'b1) begin bad++; $display("FAIL stream_stall cyc=%0d got=0 exp=1", i); end
      end
      if (i > 0) begin
        total++; if (out_valid[1] !== 1'b1 || out_data[15:8] !== 8'(i - 1)) begin
          bad++; $display("FAIL stream_data cyc=%0d got=%h/%b exp=%h/1", i, out_data[15:8], out_valid[1], 8'(i - 1));
        end else rx++;
      end
      tick();
    end
    in_valid[1] = 1'b0; out_ready[1] = 1'b0;
    total++; if (rx !== 20) begin bad++; $display("FAIL stream_count got=%0d exp=20", rx); end
  endtask

  task automatic test_clear_pulse();
    int pc;
    pc = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid[2] = 1'b1; in_data[23:16] = 8'($urandom);
      tick();
    end
    in_valid[2] = 1'b0;
    in_valid[3] = 1'b1; out_ready[3] = 1'b1;
    clear[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data[31:24] = 8'($urandom);
      if (i > 0) begin
        if (pending[2]) pc++;
        total++; if (in_ready[3] !== 1'b1 || out_valid[3] !== 1'b1 || out_data[31:24] !== mq[3][0]) begin
          bad++; $display("FAIL clr_ch3 cyc=%0d got=%h/%b/%b exp=%h/1/1", i, out_data[31:24], out_valid[3], in_ready[3], mq[3][0]);
        end
      end
      tick();
      clear[2] = 1'b0;
    end
    in_valid[3] = 1'b0; out_ready[3] = 1'b0;
    total++; if (pc !== 2) begin bad++; $display("FAIL clr_pulse_len got=%0d exp=2", pc); end
    total++; if (out_valid[2] !== 1'b0 || in_ready[2] !== 1'b1) begin
      bad++; $display("FAIL clr_after got=%b/%b exp=0/1", out_valid[2], in_ready[2]); end
    out_ready[3] = 1'b1;
    tick(); tick();
    out_ready[3] = 1'b0;
  endtask

  task automatic test_clear_hold();
    int pc;
    pc = 0;
    clear[0] = 1'b1; in_valid[0] = 1'b1; in_data[7:0] = 8'h5A;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) clear[0] = 1'b0;
      if (pending[0]) begin
        pc++;
        total++; if (in_ready[0] !== 1'b0) begin bad++; $display("FAIL hold_push_open cyc=%0d got=1 exp=0", i); end
      end
      total++; if (pending[0] !== e_pend()[0]) begin
        bad++; $display("FAIL hold_pending cyc=%0d got=%b exp=%b", i, pending[0], e_pend()[0]); end
      if (i == 6) begin
        total++; if (pending[0] !== 1'b1) begin bad++; $display("FAIL hold_release got=0 exp=1"); end
      end
      if (i == 7) begin
        total++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
          bad++; $display("FAIL hold_empty got=%b/%b exp=0/1", out_valid[0], in_ready[0]); end
        in_valid[0] = 1'b0;
      end
      tick();
    end
    total++; if (pc !== 6) begin bad++; $display("FAIL hold_len got=%0d exp=6", pc); end
    out_ready[0] = 1'b1; tick(); out_ready[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_valid[1] = 1'b1; in_data[15:8] = 8'hA1; tick();
    in_valid[1] = 1'b0; clear[1] = 1'b1; tick();
    clear[1] = 1'b0;
    total++; if (pending[1] !== 1'b1) begin bad++; $display("FAIL rstmid_isolate got=%b exp=1", pending[1]); end
    rst_ni = 1'b0;
    model_reset();
    #1;
    total++; if (in_ready !== 4'b1111 || out_valid !== 4'b0000 || pending !== 4'b0000) begin
      bad++; $display("FAIL rstmid_async got=%b/%b/%b exp=1111/0000/0000", in_ready, out_valid, pending); end
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
    total++; if (pending[1] !== 1'b0 || out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
      bad++; $display("FAIL rstmid_after got=%b/%b/%b exp=0/0/1", pending[1], out_valid[1], in_ready[1]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        in_valid[c]  = ($urandom_range(0, 3) != 0);
        out_ready[c] = ($urandom_range(0, 2) != 0);
        clear[c]     = ($urandom_range(0, 24) == 0);
        in_data[c*W +: W] = 8'($urandom);
      end
      total++; if (in_ready !== e_rdy() || out_valid !== e_vld() || pending !== e_pend()) begin
        bad++; $display("FAIL rand_hs cyc=%0d got=%b/%b/%b exp=%b/%b/%b", i, in_ready, out_valid, pending, e_rdy(), e_vld(), e_pend());
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (e_vld()[c]) begin
          total++; if (out_data[c*W +: W] !== mq[c][0]) begin
            bad++; $display("FAIL rand_data cyc=%0d ch=%0d got=%h exp=%h", i, c, out_data[c*W +: W], mq[c][0]);
          end
        end
`ifdef FIFO_MC_USAGE_EN
        total++; if (usage[c*(LD+1) +: (LD+1)] !== (LD+1)'(mq[c].size())) begin
          bad++; $display("FAIL rand_usage cyc=%0d ch=%0d got=%0d exp=%0d", i, c, usage[c*(LD+1) +: (LD+1)], mq[c].size());
        end
`endif
      end
      tick();
    end
    clear = '0; in_valid = '0; out_ready = '0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_stream();
    test_clear_pulse();
    test_clear_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
